// File: rtl/breg_wbq_if.sv
// breg_wbq_if: execute-stage request, register-file write port and hazard-check signals of breg_wbq.
`ifndef BITNESS
`define BITNESS 8
`endif
interface breg_wbq_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = `BITNESS
);
    logic                       in_valid, in_ready, in_y, hold, w, y, chk_busy;
    logic [3:0]                 in_wa, wa, chk_a;
    logic [WIDTH-1:0]           in_wval, wval;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport master (
        output in_valid, in_y, in_wa, in_wval, hold, chk_a,
        input  in_ready, w, y, wa, wval, chk_busy, count
    );
    modport slave (
        input  in_valid, in_y, in_wa, in_wval, hold, chk_a,
        output in_ready, w, y, wa, wval, chk_busy, count
    );
endinterface

// File: rtl/breg_wbq.sv
// breg_wbq: strict-FIFO write-back queue feeding the banked register file write port.
// WBQ_BYPASS_EN: an unheld request arriving at an empty queue is written in the same cycle.
`ifndef BITNESS
`define BITNESS 8
`endif
module breg_wbq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = `BITNESS
) (
    input  logic      clk,
    input  logic      rst,
    breg_wbq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic             r_y    [DEPTH];
    logic [3:0]       r_wa   [DEPTH];
    logic [WIDTH-1:0] r_wval [DEPTH];
    logic [AW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_off  [DEPTH];
    logic             w_empty, w_pop, w_push, w_byp;
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && !bus.hold;
`ifdef WBQ_BYPASS_EN
    assign w_byp   = w_empty && !bus.hold && bus.in_valid && !rst;
`else
    assign w_byp   = 1'b0;
`endif
    assign bus.in_ready = (r_count < CW'(DEPTH)) || w_pop;
    assign w_push       = bus.in_valid && bus.in_ready && !w_byp;
    assign bus.w        = w_pop || w_byp;
    assign bus.y        = w_byp ? bus.in_y    : (!w_empty && r_y[r_head]);
    assign bus.wa       = w_byp ? bus.in_wa   : (w_empty ? '0 : r_wa[r_head]);
    assign bus.wval     = w_byp ? bus.in_wval : (w_empty ? '0 : r_wval[r_head]);
    assign bus.count    = r_count;
    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
        bus.chk_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = AW'(i) - r_head;
            if (CW'(w_off[i]) < r_count &&
                (r_wa[i] == bus.chk_a || (!r_wa[i][3] && {1'b1, r_wa[i][2:0]} == bus.chk_a)))
                bus.chk_busy = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_y[i]    <= 1'b0;
                r_wa[i]   <= '0;
                r_wval[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_y[r_tail]    <= bus.in_y;
                r_wa[r_tail]   <= bus.in_wa;
                r_wval[r_tail] <= bus.in_wval;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_push != w_pop)
                r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_breg_wbq.sv
// tb_breg_wbq: randomized and directed scoreboard bench for breg_wbq against a queue model.
`timescale 1ns/1ps
module tb_breg_wbq;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        bit             y;
        bit [3:0]       wa;
        bit [WIDTH-1:0] v;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    bit   m_acc = 1'b0;
    ent_t mq[$];
    ent_t e;
    int   n_m;
    bit   pop_m, byp_m, rdy_m, busy_m;
    breg_wbq_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    breg_wbq #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask
    function automatic bit hit(input int wa, input int a);
        return wa == a || (wa < 8 && wa + 8 == a);
    endfunction
    // Monitor: model of the queue contents; pops the expected write whenever one is due.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_acc = 1'b0;
        end else begin
            n_m    = mq.size();
            pop_m  = n_m != 0 && !bus.hold;
            byp_m  = BYP && n_m == 0 && !bus.hold && bus.in_valid;
            rdy_m  = n_m < DEPTH || pop_m;
            busy_m = 1'b0;
            foreach (mq[k]) if (hit(mq[k].wa, bus.chk_a)) busy_m = 1'b1;
            chk("count", bus.count, n_m);
            chk("in_ready", bus.in_ready, rdy_m);
            chk("w", bus.w, pop_m || byp_m);
            chk("chk_busy", bus.chk_busy, busy_m);
            e = byp_m ? ent_t'{bus.in_y, bus.in_wa, bus.in_wval} : (n_m == 0 ? ent_t'(0) : mq[0]);
            chk("y", bus.y, e.y);
            chk("wa", bus.wa, e.wa);
            chk("wval", bus.wval, e.v);
            if (pop_m) void'(mq.pop_front());
            m_acc = bus.in_valid && rdy_m;
            if (m_acc && !byp_m) mq.push_back(ent_t'{bus.in_y, bus.in_wa, bus.in_wval});
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_acc(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!m_acc && n < 100);
        if (!m_acc) chk("accept_timeout", 0, 1);
    endtask
    task automatic req(input bit y, input bit [3:0] wa, input bit [WIDTH-1:0] v, output int n);
        bus.in_valid = 1'b1;
        bus.in_y     = y;
        bus.in_wa    = wa;
        bus.in_wval  = v;
        wait_acc(n);
    endtask
    task automatic wait_empty();
        int n = 0;
        while (mq.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_model", mq.size(), 0);
        chk("drain_count", bus.count, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_y     = 1'b0;
        bus.in_wa    = '0;
        bus.in_wval  = '0;
        bus.hold     = 1'b0;
        bus.chk_a    = '0;
        #1;
        chk("rst_w", bus.w, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_busy", bus.chk_busy, 0);
        chk("rst_wval", bus.wval, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        // Single push, emitted the next cycle (same cycle with bypass).
        req(1'b1, 4'd3, 8'h5A, n);
        idle();
        #1;
        chk("t1_w", bus.w, !BYP);
        if (!BYP) begin
            chk("t1_wa", bus.wa, 3);
            chk("t1_wval", bus.wval, 8'h5A);
            chk("t1_y", bus.y, 1);
        end
        cyc();
        chk("t1_w_after", bus.w, 0);
        chk("t1_count", bus.count, 0);
        // Same-cycle vs next-cycle emission on an empty queue.
        bus.in_valid = 1'b1;
        bus.in_y     = 1'b0;
        bus.in_wa    = 4'd5;
        bus.in_wval  = 8'h0F;
        #1;
        chk("t6_w_same", bus.w, BYP);
        if (BYP) chk("t6_wa_same", bus.wa, 5);
        chk("t6_count_same", bus.count, 0);
        wait_acc(n);
        idle();
        #1;
        chk("t6_w_next", bus.w, !BYP);
        if (!BYP) chk("t6_wa_next", bus.wa, 5);
        cyc();
        // Fill under hold, stall a fifth request, then release.
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) req(1'b1, 4'(i), 8'(8'h10 + i), n);
        bus.in_wa   = 4'd4;
        bus.in_wval = 8'h14;
        repeat (3) cyc();
        chk("t2_full_count", bus.count, 4);
        chk("t2_full_ready", bus.in_ready, 0);
        bus.hold = 1'b0;
        wait_acc(n);
        chk("t2_release_lat", n, 1);
        idle();
        wait_empty();
        // Full queue streaming: one in, one out every cycle.
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) req(1'($urandom), 4'($urandom), 8'($urandom), n);
        bus.hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            req(1'($urandom), 4'($urandom), 8'($urandom), n);
            chk("t3_lat", n, 1);
        end
        idle();
        wait_empty();
        // Hazard check including the mirrored low bank.
        bus.hold = 1'b1;
        req(1'b1, 4'd2, 8'h22, n);
        idle();
        bus.chk_a = 4'd10;
        #1 chk("t4_a10", bus.chk_busy, 1);
        cyc();
        bus.chk_a = 4'd2;
        #1 chk("t4_a2", bus.chk_busy, 1);
        cyc();
        bus.chk_a = 4'd3;
        #1 chk("t4_a3", bus.chk_busy, 0);
        cyc();
        bus.hold = 1'b0;
        wait_empty();
        bus.hold = 1'b1;
        req(1'b0, 4'd10, 8'h33, n);
        idle();
        bus.chk_a = 4'd2;
        #1 chk("t4_hi_a2", bus.chk_busy, 0);
        cyc();
        bus.hold = 1'b0;
        wait_empty();
        // Asynchronous reset with three queued writes.
        bus.hold = 1'b1;
        for (int i = 1; i <= 3; i++) req(1'b1, 4'(i), 8'(8'hA0 + i), n);
        idle();
        bus.chk_a = 4'd2;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("t5_w", bus.w, 0);
        chk("t5_count", bus.count, 0);
        chk("t5_busy", bus.chk_busy, 0);
        chk("t5_ready", bus.in_ready, 1);
        cyc();
        bus.hold = 1'b0;
        rst = 1'b0;
        repeat (5) cyc();
        chk("t5_no_stale", bus.w, 0);
        // Random traffic; a request stays presented until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid || m_acc) begin
                bus.in_valid = $urandom_range(0, 9) < 6;
                bus.in_y     = 1'($urandom);
                bus.in_wa    = 4'($urandom);
                bus.in_wval  = 8'($urandom);
            end
            bus.hold  = $urandom_range(0, 9) < 3;
            bus.chk_a = 4'($urandom);
            cyc();
        end
        idle();
        bus.hold = 1'b0;
        wait_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/breg_wbq.md
Name: breg_wbq

Overview:
- Write-back queue that sits directly upstream of the banked register file write port (w, y, wa, wval).
- Buffers register write requests from the execute stage in strict FIFO order.
- Drains at most one request per cycle into the register file, and only when not held.
- Provides a pending-write hazard check so the read stage can stall when a queued write targets its read address.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, 2..16.
- WIDTH, `BITNESS, data width; must match the register file word width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  execute stage presents a write request.
- in_ready  output  1  queue accepts the request this cycle.
- in_y  input  1  1 = overwrite, 0 = XOR into the current value.
- in_wa  input  4  destination register address.
- in_wval  input  WIDTH  write data.
- hold  input  1  1 = suppress draining this cycle (write port borrowed elsewhere).
- w  output  1  write strobe to the register file.
- y  output  1  mode to the register file.
- wa  output  4  address to the register file.
- wval  output  WIDTH  data to the register file.
- chk_a  input  4  read address to hazard-check.
- chk_busy  output  1  a queued write affects chk_a.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: DEPTH entries of {y, wa, wval}; head pointer, tail pointer, count.
- Reset: clk and rst as already decided, reset asynchronous active-high.
  - Pointers and count go to 0; all entry fields go to 0.
  - Outputs during and after reset: w=0, y=0, wa=0, wval=0, chk_busy=0, count=0, in_ready=1.
- Reset mid-operation: queued writes are discarded, never emitted.
- Pop: pop = (count!=0) && !hold, derived from registered state only (no path from in_valid).
  - w = pop; y, wa and wval show the head entry.
  - When pop=0, y, wa and wval still show the head entry (don't-care for the register file); when empty they are 0.
  - The head advances on the clock edge where pop=1.
- Push: push = in_valid && in_ready.
  - in_ready = (count<DEPTH) || pop, so push is allowed when full if a pop happens the same cycle.
  - The entry is written at the tail on the clock edge.
- Count update on each edge:
  - count+1 for push only.
  - count-1 for pop only.
  - Unchanged for both or neither.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO with no reordering or coalescing. XOR-mode writes are order-dependent.
- Latency: the earliest emission is the cycle after acceptance (without bypass).
- Hazard check: chk_busy=1 if any occupied entry e satisfies either condition:
  - e.wa==chk_a, or
  - e.wa<8 and e.wa+8==chk_a (mirrored low-bank write).
- The hazard check is combinational over occupied entries only. The head entry being popped this cycle still counts.
- Empty + hold: w=0; pushes still accepted.
- Full + hold: in_ready=0; in_valid is ignored and the upstream stage must hold its request.
- in_valid deasserted: no state change except from pop.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: when count==0, hold==0 and in_valid==1, the request goes combinationally to w/y/wa/wval in the same cycle and is not stored.
  - in_ready=1 and count stays 0.
  - chk_busy does not include the bypassed request.
  - In all other conditions, behaviour matches the undefined case.
- Undefined: no combinational path from in_* to w/y/wa/wval; minimum latency is 1 cycle.

Test Plan:
1. Reset, then a single push {y=1, wa=3, wval=0x5A}.
   -> Next cycle: w=1, wa=3, wval=0x5A, y=1.
   -> Following cycle: w=0, count=0.
2. hold=1; push 4 entries wa=0..3.
   -> count=4, in_ready=0.
   -> 5th request stalls and is not lost.
   -> Release hold: entries emitted wa=0,1,2,3 on consecutive cycles, then the 5th.
3. Full queue with hold=0 and in_valid=1 continuous.
   -> in_ready=1 every cycle; count stays 4; one write per cycle; order preserved.
4. Queue one entry with wa=2.
   -> chk_a=10: chk_busy=1.
   -> chk_a=2: chk_busy=1.
   -> chk_a=3: chk_busy=0.
   Queue one entry with wa=10.
   -> chk_a=2: chk_busy=0.
5. Assert rst asynchronously between edges with count=3.
   -> w=0, count=0, chk_busy=0 immediately.
   -> After release, no stale writes are emitted.
6. With WBQ_BYPASS_EN, empty queue, push {y=0, wa=5, wval=0x0F}.
   -> Same cycle: w=1, wa=5, count=0.
   Without WBQ_BYPASS_EN:
   -> w=0 that cycle, w=1 the next.
